// File: rtl/pca9685_channel_writer.sv
// PCA9685 channel writer: turns one PWM channel update into four LEDn register writes
// through the i2c_controller execute/busy handshake. Optional macro PCA9685_INIT_EN adds a MODE1 write after reset.
module pca9685_channel_writer #(
   parameter logic [6:0]  DEV_ADDR    = 7'h40,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  channel_i,
   input  logic [11:0] on_i,
   input  logic [11:0] off_i,
   input  logic        full_on_i,
   input  logic        full_off_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [6:0]  address_o,
   output logic        rw_o,
   output logic [7:0]  register_o,
   output logic [7:0]  data_o,
   output logic        execute_o,
   input  logic        ctrl_busy_i
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_LOAD, S_ISSUE, S_WAIT, S_DONE, S_ABORT
   } state_e;

`ifdef PCA9685_INIT_EN
   localparam state_e RESET_STATE = S_INIT;
`else
   localparam state_e RESET_STATE = S_IDLE;
`endif

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      ch_q, ch_d;
   logic [11:0]     on_q, on_d, off_q, off_d;
   logic            fon_q, fon_d, foff_q, foff_d;
   logic            init_q, init_d;
   logic            busy_q, busy_d, done_q, done_d, error_q, error_d, execute_q, execute_d;
   logic [7:0]      register_q, register_d, data_q, data_d;
   logic [7:0]      base;

   assign base = 8'h06 + {2'b00, ch_q, 2'b00};

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d    = state_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      ch_d       = ch_q;
      on_d       = on_q;
      off_d      = off_q;
      fon_d      = fon_q;
      foff_d     = foff_q;
      init_d     = init_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      execute_d  = execute_q;
      register_d = register_q;
      data_d     = data_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               ch_d    = channel_i;
               on_d    = on_i;
               off_d   = off_i;
               fon_d   = full_on_i;
               foff_d  = full_off_i;
               idx_d   = 2'd0;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_INIT: begin
            init_d  = 1'b1;
            busy_d  = 1'b1;
            idx_d   = 2'd0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (init_q) begin
               register_d = 8'h00;
               data_d     = 8'h20;
            end else begin
               register_d = base + {6'b0, idx_q};
               unique case (idx_q)
                  2'd0: data_d = on_q[7:0];
                  2'd1: data_d = {3'b000, fon_q, on_q[11:8]};
                  2'd2: data_d = off_q[7:0];
                  2'd3: data_d = {3'b000, foff_q, off_q[11:8]};
               endcase
            end
            execute_d = 1'b1;
            timer_d   = '0;
            state_d   = S_ISSUE;
         end
         S_ISSUE: begin
            // A controller already busy on entry is taken as the acknowledge.
            if (ctrl_busy_i) begin
               execute_d = 1'b0;
               state_d   = S_WAIT;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
               execute_d = 1'b0;
               state_d   = S_ABORT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WAIT: begin
            if (!ctrl_busy_i) begin
               if (init_q || idx_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            init_d  = 1'b0;
            idx_d   = 2'd0;
            state_d = S_IDLE;
         end
         S_ABORT: begin
            done_d    = 1'b1;
            error_d   = 1'b1;
            busy_d    = 1'b0;
            execute_d = 1'b0;
            init_d    = 1'b0;
            idx_d     = 2'd0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RESET_STATE;
         idx_q      <= '0;
         timer_q    <= '0;
         ch_q       <= '0;
         on_q       <= '0;
         off_q      <= '0;
         fon_q      <= 1'b0;
         foff_q     <= 1'b0;
         init_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         execute_q  <= 1'b0;
         register_q <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         ch_q       <= ch_d;
         on_q       <= on_d;
         off_q      <= off_d;
         fon_q      <= fon_d;
         foff_q     <= foff_d;
         init_q     <= init_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         execute_q  <= execute_d;
         register_q <= register_d;
         data_q     <= data_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign execute_o  = execute_q;
   assign register_o = register_q;
   assign data_o     = data_q;
   assign address_o  = DEV_ADDR;
   assign rw_o       = 1'b0;

endmodule
